// File: rtl/aes_pkg.sv
// aes_pkg: shared AES controller types, state encoding and round-count constants
package aes_pkg;

    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;

    typedef enum logic [2:0] {
        AES_128 = 3'b001,
        AES_192 = 3'b010,
        AES_256 = 3'b100
    } key_len_e;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        DONE,
        CLEAR
    } round_ctrl_e;

    localparam logic [3:0] NUM_ROUNDS_128 = 4'd10;
    localparam logic [3:0] NUM_ROUNDS_256 = 4'd14;

    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_LOAD  = 2'd1;
    localparam logic [1:0] SEL_ROUND = 2'd2;
    localparam logic [1:0] SEL_CLEAR = 2'd3;

endpackage

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES cipher round sequencer driving external sub-bytes / key-expand stages
//   clk_i, rst_ni                   clock, synchronous active-low reset
//   in_valid_i/in_ready_o           block request handshake (op_i, key_len_i sampled at accept)
//   clear_i                         abort and clear, highest priority
//   state_sel_o, mc_bypass_o        datapath state mux select, skip mix-columns on final round
//   round_o, op_o                   current round index, latched operation
//   sb_en_o/sb_req_i/sb_ack_o       sub-bytes enable / result-ready / acknowledge
//   key_en_o/key_req_i/key_ack_o    key-expand enable / result-ready / acknowledge
//   key_clear_o                     key-expand clear pulse
//   out_valid_o/out_ready_i         result handshake
//   err_o                           pulse on a rejected request
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter bit AES256Enable = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [1:0] op_i,
    input  logic [2:0] key_len_i,
    input  logic       clear_i,
    output logic [1:0] state_sel_o,
    output logic       mc_bypass_o,
    output logic [3:0] round_o,
    output logic [1:0] op_o,
    output logic       sb_en_o,
    input  logic       sb_req_i,
    output logic       sb_ack_o,
    output logic       key_en_o,
    input  logic       key_req_i,
    output logic       key_ack_o,
    output logic       key_clear_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       err_o
);

    round_ctrl_e r_state, w_state_nxt;
    logic [3:0]  r_round, r_nrounds;
    logic [1:0]  r_op;
    logic        r_sb_seen, r_key_seen;
    logic        w_key_ok, w_idle_req, w_accept, w_reject;
    logic        w_sb_got, w_key_got, w_round_done, w_last;

    assign w_key_ok     = (key_len_i == AES_128) || (AES256Enable && key_len_i == AES_256);
    assign w_idle_req   = r_state == IDLE && in_valid_i && !clear_i;
    assign w_accept     = w_idle_req && w_key_ok;
    assign w_reject     = w_idle_req && !w_key_ok;
    // a request counts if it arrived in an earlier cycle of this round or arrives now
    assign w_sb_got     = r_sb_seen || sb_req_i;
    assign w_key_got    = r_key_seen || key_req_i;
    // a clear in the same cycle drops the round, so nothing is acknowledged
    assign w_round_done = r_state == ROUND && w_sb_got && w_key_got && !clear_i;
    assign w_last       = r_round == r_nrounds;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_accept ? INIT : IDLE;
            INIT:    w_state_nxt = ROUND;
            ROUND:   w_state_nxt = (w_round_done && w_last) ? DONE : ROUND;
            DONE:    w_state_nxt = out_ready_i ? IDLE : DONE;
            CLEAR:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (clear_i) w_state_nxt = CLEAR;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_round    <= '0;
            r_nrounds  <= '0;
            r_op       <= '0;
            r_sb_seen  <= 1'b0;
            r_key_seen <= 1'b0;
        end else if (clear_i) begin
            r_round    <= '0;
            r_sb_seen  <= 1'b0;
            r_key_seen <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= op_i;
                r_nrounds <= (key_len_i == AES_256) ? NUM_ROUNDS_256 : NUM_ROUNDS_128;
                r_round   <= '0;
            end
            if (r_state == INIT) r_round <= 4'd1;
            if (w_round_done) begin
                r_sb_seen  <= 1'b0;
                r_key_seen <= 1'b0;
                if (!w_last) r_round <= r_round + 4'd1;
            end else if (r_state == ROUND) begin
                r_sb_seen  <= w_sb_got;
                r_key_seen <= w_key_got;
            end
        end
    end

    always_comb begin
        in_ready_o  = r_state == IDLE;
        state_sel_o = r_state == INIT ? SEL_LOAD : w_round_done ? SEL_ROUND :
                      r_state == CLEAR ? SEL_CLEAR : SEL_HOLD;
        key_clear_o = r_state == INIT || r_state == CLEAR;
        sb_en_o     = r_state == ROUND && !r_sb_seen;
        key_en_o    = r_state == ROUND && !r_key_seen;
        sb_ack_o    = w_round_done;
        key_ack_o   = w_round_done;
        mc_bypass_o = r_state == ROUND && w_last;
        out_valid_o = r_state == DONE;
        round_o     = r_round;
        op_o        = r_op;
        err_o       = w_reject && rst_ni;
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: self-checking bench for aes_round_ctrl with latency-programmable stage stubs
module tb_aes_round_ctrl;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       in_valid_i = 1'b0, in_ready_o;
    logic [1:0] op_i = '0;
    logic [2:0] key_len_i = '0;
    logic       clear_i = 1'b0;
    logic [1:0] state_sel_o;
    logic       mc_bypass_o;
    logic [3:0] round_o;
    logic [1:0] op_o;
    logic       sb_en_o, sb_req_i, sb_ack_o;
    logic       key_en_o, key_req_i, key_ack_o;
    logic       key_clear_o, out_valid_o, err_o;
    logic       out_ready_i = 1'b0;

    logic       in_valid0 = 1'b0, clear0 = 1'b0;
    logic       in_ready0, mc_bypass0, sb_en0, sb_ack0, key_en0, key_ack0, key_clear0, out_valid0, err0;
    logic [1:0] state_sel0, op0;
    logic [3:0] round0;

    int vectors = 0;
    int miscompares = 0;
    int sb_lat = 0, key_lat = 0;
    int sb_cnt = 0, key_cnt = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.AES256Enable(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_i(op_i), .key_len_i(key_len_i), .clear_i(clear_i), .state_sel_o(state_sel_o),
        .mc_bypass_o(mc_bypass_o), .round_o(round_o), .op_o(op_o),
        .sb_en_o(sb_en_o), .sb_req_i(sb_req_i), .sb_ack_o(sb_ack_o),
        .key_en_o(key_en_o), .key_req_i(key_req_i), .key_ack_o(key_ack_o),
        .key_clear_o(key_clear_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .err_o(err_o)
    );

    aes_round_ctrl #(.AES256Enable(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .op_i(op_i), .key_len_i(key_len_i), .clear_i(clear0), .state_sel_o(state_sel0),
        .mc_bypass_o(mc_bypass0), .round_o(round0), .op_o(op0),
        .sb_en_o(sb_en0), .sb_req_i(1'b0), .sb_ack_o(sb_ack0),
        .key_en_o(key_en0), .key_req_i(1'b0), .key_ack_o(key_ack0),
        .key_clear_o(key_clear0), .out_valid_o(out_valid0), .out_ready_i(1'b1),
        .err_o(err0)
    );

    // stage stubs: result ready once enable has been high for the programmed number of cycles
    assign sb_req_i  = sb_en_o && (sb_cnt >= sb_lat);
    assign key_req_i = key_en_o && (key_cnt >= key_lat);
    always @(posedge clk) begin
        sb_cnt  <= (!sb_en_o || sb_req_i) ? 0 : sb_cnt + 1;
        key_cnt <= (!key_en_o || key_req_i) ? 0 : key_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Whole-transaction reference: with stub latencies ls/lk every round takes max(ls,lk)+1
    // cycles, so accept at cycle 0 gives INIT at 1, round k spanning cycles 2+(k-1)*p .. 1+k*p,
    // and out_valid at 2+n*p.
    task automatic run_txn(input logic [1:0] op, input logic [2:0] kl, input int ls, input int lk,
                           input int hold, input string name);
        int n, p, done, o;
        logic [3:0] er;
        logic fin, in_rnd;
        logic [14:0] got, exp;
        n = (kl == AES_256) ? 14 : 10;
        p = (ls > lk ? ls : lk) + 1;
        done = 2 + n * p;
        sb_lat = ls;
        key_lat = lk;
        in_valid_i = 1'b1;
        op_i = op;
        key_len_i = kl;
        #1;
        vectors++;
        if (in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept: in_ready_o=%b expected 1", name, in_ready_o);
        end
        step();
        for (int c = 1; c < done; c++) begin
            in_valid_i = 1'($urandom_range(0, 1));
            op_i = 2'($urandom);
            key_len_i = 3'($urandom);
            out_ready_i = 1'($urandom_range(0, 1));
            #1;
            in_rnd = c >= 2;
            o = in_rnd ? (c - 2) % p : 0;
            er = in_rnd ? 4'(1 + (c - 2) / p) : 4'd0;
            fin = in_rnd && o == p - 1;
            exp = {er, (c == 1) ? 2'd1 : fin ? 2'd2 : 2'd0, in_rnd && er == 4'(n), 1'b0, 1'b0,
                   fin, fin, c == 1, in_rnd && o <= ls, in_rnd && o <= lk, 1'b0};
            got = {round_o, state_sel_o, mc_bypass_o, out_valid_o, in_ready_o,
                   sb_ack_o, key_ack_o, key_clear_o, sb_en_o, key_en_o, err_o};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
            end
            step();
        end
        in_valid_i = 1'b0;
        out_ready_i = hold == 0;
        #1;
        vectors++;
        if ({out_valid_o, in_ready_o, state_sel_o, op_o} !== {1'b1, 1'b0, 2'd0, op}) begin
            miscompares++;
            $display("FAIL %s done cycle %0d: out_valid=%b in_ready=%b sel=%0d op=%0d expected 1 0 0 %0d",
                     name, done, out_valid_o, in_ready_o, state_sel_o, op_o, op);
        end
        for (int h = 1; h <= hold; h++) begin
            step();
            out_ready_i = h == hold;
            #1;
            vectors++;
            if ({out_valid_o, in_ready_o} !== 2'b10) begin
                miscompares++;
                $display("FAIL %s hold %0d: out_valid/in_ready=%b expected 10", name, h, {out_valid_o, in_ready_o});
            end
        end
        step();
        out_ready_i = 1'b0;
        #1;
        vectors++;
        if ({out_valid_o, in_ready_o, state_sel_o} !== 4'b0100) begin
            miscompares++;
            $display("FAIL %s idle: out_valid/in_ready/sel=%b expected 0100", name,
                     {out_valid_o, in_ready_o, state_sel_o});
        end
    endtask

    task automatic test_reset();
        logic [16:0] got;
        rst_ni = 1'b0;
        step();
        step();
        got = {in_ready_o, state_sel_o, mc_bypass_o, round_o, op_o, sb_en_o, sb_ack_o,
               key_en_o, key_ack_o, key_clear_o, out_valid_o, err_o};
        vectors++;
        if (got !== 17'h10000) begin
            miscompares++;
            $display("FAIL reset_held: got %h expected 10000", got);
        end
        rst_ni = 1'b1;
        #1;
        got = {in_ready_o, state_sel_o, mc_bypass_o, round_o, op_o, sb_en_o, sb_ack_o,
               key_en_o, key_ack_o, key_clear_o, out_valid_o, err_o};
        vectors++;
        if (got !== 17'h10000) begin
            miscompares++;
            $display("FAIL reset_released: got %h expected 10000", got);
        end
        step();
    endtask

    task automatic test_aes128();
        run_txn(CIPH_FWD, AES_128, 0, 0, 0, "aes128_zero_lat");
    endtask

    task automatic test_aes256_latency();
        run_txn(CIPH_INV, AES_256, 3, 1, 0, "aes256_lat31");
    endtask

    task automatic test_invalid_key();
        logic [2:0] bad [5] = '{3'b010, 3'b011, 3'b000, 3'b111, 3'b110};
        foreach (bad[i]) begin
            in_valid_i = 1'b1;
            key_len_i = bad[i];
            #1;
            vectors++;
            if ({err_o, in_ready_o} !== 2'b11) begin
                miscompares++;
                $display("FAIL invalid_key %b: err/in_ready=%b expected 11", bad[i], {err_o, in_ready_o});
            end
            step();
            in_valid_i = 1'b0;
            #1;
            vectors++;
            if ({err_o, in_ready_o, key_clear_o, state_sel_o} !== 5'b01000) begin
                miscompares++;
                $display("FAIL invalid_key_after %b: err/rdy/kclr/sel=%b expected 01000", bad[i],
                         {err_o, in_ready_o, key_clear_o, state_sel_o});
            end
        end
        in_valid0 = 1'b1;
        key_len_i = AES_256;
        #1;
        vectors++;
        if ({err0, in_ready0} !== 2'b11) begin
            miscompares++;
            $display("FAIL no256_reject: err/in_ready=%b expected 11", {err0, in_ready0});
        end
        step();
        in_valid0 = 1'b0;
        #1;
        vectors++;
        if ({err0, in_ready0, key_clear0, state_sel0} !== 5'b01000) begin
            miscompares++;
            $display("FAIL no256_after: err/rdy/kclr/sel=%b expected 01000", {err0, in_ready0, key_clear0, state_sel0});
        end
    endtask

    task automatic test_clear_mid();
        bit found = 0;
        bit seen_valid = 0;
        sb_lat = 0;
        key_lat = 0;
        in_valid_i = 1'b1;
        op_i = CIPH_FWD;
        key_len_i = AES_128;
        step();
        in_valid_i = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #1;
            if (round_o == 4'd5) found = 1;
            else step();
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL clear_reach_round5: round_o=%0d expected 5", round_o);
        end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        #1;
        vectors++;
        if ({state_sel_o, key_clear_o, round_o, out_valid_o, in_ready_o} !== 9'b11_1_0000_0_0) begin
            miscompares++;
            $display("FAIL clear_cycle: sel/kclr/round/ov/rdy=%b expected 111000000",
                     {state_sel_o, key_clear_o, round_o, out_valid_o, in_ready_o});
        end
        step();
        #1;
        vectors++;
        if ({in_ready_o, state_sel_o, key_clear_o} !== 4'b1000) begin
            miscompares++;
            $display("FAIL clear_to_idle: rdy/sel/kclr=%b expected 1000", {in_ready_o, state_sel_o, key_clear_o});
        end
        for (int i = 0; i < 20; i++) begin
            if (out_valid_o) seen_valid = 1;
            step();
        end
        vectors++;
        if (seen_valid) begin
            miscompares++;
            $display("FAIL clear_no_output: out_valid seen=%b expected 0", seen_valid);
        end
    endtask

    task automatic test_clear_idle();
        in_valid_i = 1'b1;
        key_len_i = AES_128;
        clear_i = 1'b1;
        #1;
        vectors++;
        if (err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_idle_err: err_o=%b expected 0", err_o);
        end
        step();
        in_valid_i = 1'b0;
        clear_i = 1'b0;
        #1;
        vectors++;
        if ({in_ready_o, state_sel_o, key_clear_o, round_o} !== 8'b0_11_1_0000) begin
            miscompares++;
            $display("FAIL clear_idle_cycle: rdy/sel/kclr/round=%b expected 01110000",
                     {in_ready_o, state_sel_o, key_clear_o, round_o});
        end
        step();
        #1;
        vectors++;
        if ({in_ready_o, state_sel_o, key_clear_o} !== 4'b1000) begin
            miscompares++;
            $display("FAIL clear_idle_after: rdy/sel/kclr=%b expected 1000", {in_ready_o, state_sel_o, key_clear_o});
        end
    endtask

    task automatic test_back_pressure();
        run_txn(CIPH_FWD, AES_128, 1, 2, 7, "backpressure");
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        logic [16:0] got;
        sb_lat = 1;
        key_lat = 1;
        in_valid_i = 1'b1;
        op_i = CIPH_INV;
        key_len_i = AES_128;
        step();
        in_valid_i = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            #1;
            if (round_o == 4'd3) found = 1;
            else step();
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL reset_reach_round3: round_o=%0d expected 3", round_o);
        end
        rst_ni = 1'b0;
        step();
        got = {in_ready_o, state_sel_o, mc_bypass_o, round_o, op_o, sb_en_o, sb_ack_o,
               key_en_o, key_ack_o, key_clear_o, out_valid_o, err_o};
        vectors++;
        if (got !== 17'h10000) begin
            miscompares++;
            $display("FAIL reset_mid_held: got %h expected 10000", got);
        end
        step();
        rst_ni = 1'b1;
        #1;
        got = {in_ready_o, state_sel_o, mc_bypass_o, round_o, op_o, sb_en_o, sb_ack_o,
               key_en_o, key_ack_o, key_clear_o, out_valid_o, err_o};
        vectors++;
        if (got !== 17'h10000) begin
            miscompares++;
            $display("FAIL reset_mid_released: got %h expected 10000", got);
        end
        step();
        run_txn(CIPH_FWD, AES_256, 2, 0, 1, "after_reset");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            run_txn($urandom_range(0, 1) ? CIPH_INV : CIPH_FWD,
                    $urandom_range(0, 1) ? AES_256 : AES_128,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), "random");
            step();
        end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes256_latency();
        test_invalid_key();
        test_clear_mid();
        test_clear_idle();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter AES256Enable, default 1: 1 accepts 256-bit keys; 0 rejects them as invalid.
REQ-002 clk_i  input  1  sole clock, rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 in_valid_i  input  1  new block request.
REQ-005 in_ready_o  output  1  request accepted when in_valid_i&&in_ready_o.
REQ-006 op_i  input  2  aes_pkg ciph_op_e, sampled at accept.
REQ-007 key_len_i  input  3  aes_pkg key_len_e (one-hot 128/192/256), sampled at accept.
REQ-008 clear_i  input  1  abort and clear request.
REQ-009 state_sel_o  output  2  datapath state mux: 0 hold, 1 load input+add key, 2 round result, 3 clear.
REQ-010 mc_bypass_o  output  1  skip mix-columns (final round).
REQ-011 round_o  output  4  current round index.
REQ-012 op_o  output  2  latched operation.
REQ-013 sb_en_o / sb_req_i / sb_ack_o  out/in/out  1 each  sub-bytes enable, result-ready, acknowledge.
REQ-014 key_en_o / key_req_i / key_ack_o  out/in/out  1 each  key-expand enable, result-ready, acknowledge.
REQ-015 key_clear_o  output  1  key-expand clear pulse.
REQ-016 out_valid_o  input-side handshake output  1  result valid; out_ready_i input 1 consumer ready.
REQ-017 err_o  output  1  one-cycle pulse on a rejected request.

Function
REQ-018 The FSM SHALL have states IDLE, INIT, ROUND, DONE, CLEAR.
REQ-019 IDLE: in_ready_o=1. Accepting a request with a valid key length SHALL latch op and the round count (10 for AES-128, 14 for AES-256), set round_o=0 and go to INIT.
REQ-020 An invalid key length SHALL not be accepted. This covers 192 always, 256 when AES256Enable=0, and non-one-hot values. Such a request SHALL pulse err_o and keep the FSM in IDLE.
REQ-021 INIT lasts exactly 1 cycle: state_sel_o=1, key_clear_o=1. It then goes to ROUND with round_o=1.
REQ-022 ROUND: sb_en_o SHALL stay high until sb_req_i has been seen, and key_en_o SHALL stay high until key_req_i has been seen. Each arrival is latched in a sticky flag.
REQ-023 When both flags are set (or both requests arrive this cycle), sb_ack_o, key_ack_o and state_sel_o=2 SHALL all assert for exactly that cycle. The flags SHALL then clear.
REQ-024 On that completion cycle, if round_o equals the round count the FSM SHALL go to DONE. Otherwise round_o SHALL increment.
REQ-025 mc_bypass_o SHALL be 1 exactly while in ROUND with round_o equal to the round count.
REQ-026 DONE: out_valid_o=1 and state_sel_o=0. The FSM SHALL hold until out_ready_i=1, then return to IDLE.
REQ-027 Outside INIT and ROUND completion cycles, state_sel_o SHALL be 0 except in CLEAR.
REQ-028 clear_i SHALL take priority over all other transitions in any state. It SHALL go to CLEAR, dropping any in-flight operation without output.
REQ-029 CLEAR lasts exactly 1 cycle: state_sel_o=3, key_clear_o=1, flags and round_o zeroed. It then goes to IDLE.
REQ-030 in_ready_o SHALL be 0 outside IDLE; in_valid_i while busy SHALL be ignored.
REQ-031 A clear_i in IDLE coincident with in_valid_i SHALL win; the request is not accepted.
REQ-032 Zero-latency stubs (req asserted when en is asserted) SHALL give, for accept at cycle 0: INIT at cycle 1, rounds at cycles 2..N+1, out_valid_o first high at cycle N+2.

Reset
REQ-033 While rst_ni=0 at a clock edge, the block SHALL enter IDLE with round_o=0, op_o=0 and both flags cleared.
REQ-034 In reset, all outputs SHALL be 0 except in_ready_o=1 in the first post-reset cycle.
REQ-035 Reset mid-operation SHALL abandon the block without out_valid_o or err_o.

Structure
REQ-036 The state enum and the round-count constants 10/14 SHALL live in aes_pkg.
REQ-037 ciph_op_e and key_len_e SHALL be reused from aes_pkg.
REQ-038 The block SHALL be a single module with no sub-modules; the datapath stages are external.

Verification
REQ-039 AES-128 request, zero-latency stubs, out_ready_i=1: out_valid_o at cycle 12, mc_bypass_o high only at cycle 11, round_o sequence 1..10.
REQ-040 AES-256, sub-bytes stub latency 3 and key stub latency 1: each round takes 4 cycles, acks are coincident, and out_valid_o arrives at cycle 2+14*4=58.
REQ-041 key_len_i=3'b010, or 3'b100 with AES256Enable=0: err_o pulses for 1 cycle, in_ready_o stays 1, no INIT.
REQ-042 clear_i asserted in round 5: next cycle state_sel_o=3 and key_clear_o=1, then IDLE, never out_valid_o.
REQ-043 out_ready_i held 0 for 7 cycles in DONE: out_valid_o stays high and in_ready_o stays 0; IDLE follows the ready cycle.
REQ-044 rst_ni=0 during round 3, then released: IDLE, all outputs at reset values, next request completes normally.
